// File: rtl/game_pkg.sv
// Shared definitions for the fighting-game hit logic: FSM states, winner codes
// and the saturating damage helper.
package game_pkg;

  localparam int unsigned HEALTH_W = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FIGHT = 2'd1,
    ST_KO    = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    WIN_NONE = 2'b00,
    WIN_P1   = 2'b01,
    WIN_P2   = 2'b10,
    WIN_DRAW = 2'b11
  } winner_e;

  // Health never wraps: any hit at or above remaining health leaves zero.
  function automatic logic [HEALTH_W-1:0] apply_damage(
    input logic [HEALTH_W-1:0] health,
    input logic [HEALTH_W-1:0] dmg
  );
    return (health <= dmg) ? '0 : health - dmg;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running game-tick divider: one-cycle enable every TICK_DIV clocks.
module tick_gen #(
  parameter int unsigned TICK_DIV = 2500000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/hit_resolver.sv
// Round control and hit resolution for two players: edge-qualified attacks,
// saturating health, per-player invulnerability cooldown and KO/winner logic.
module hit_resolver
  import game_pkg::*;
#(
  parameter int unsigned MAX_HEALTH     = 100,
  parameter int unsigned DAMAGE         = 10,
  parameter int unsigned TICK_DIV       = 2500000,
  parameter int unsigned COOLDOWN_TICKS = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                collision,
  input  logic                p1_attack,
  input  logic                p2_attack,
  input  logic                round_start,
  output logic [HEALTH_W-1:0] p1_health,
  output logic [HEALTH_W-1:0] p2_health,
  output logic                p1_hit,
  output logic                p2_hit,
  output logic                ko,
  output logic [1:0]          winner
);

  localparam int unsigned CD_W = (COOLDOWN_TICKS > 0) ? $clog2(COOLDOWN_TICKS + 1) : 1;
  localparam logic [CD_W-1:0]     CD_LOAD = CD_W'(COOLDOWN_TICKS);
  localparam logic [HEALTH_W-1:0] H_MAX   = HEALTH_W'(MAX_HEALTH);
  localparam logic [HEALTH_W-1:0] H_DMG   = HEALTH_W'(DAMAGE);

  state_e              state_q, state_d;
  winner_e             win_q, win_d;
  logic [HEALTH_W-1:0] p1_health_q, p1_health_d, p2_health_q, p2_health_d;
  logic [CD_W-1:0]     p1_cd_q, p1_cd_d, p2_cd_q, p2_cd_d;
  logic                p1_att_q, p2_att_q;
  logic                p1_hit_q, p1_hit_d, p2_hit_q, p2_hit_d;
  logic                tick;
  logic                p1_evt, p2_evt;
  logic                land_on_p1, land_on_p2;

  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  assign p1_evt = p1_attack & ~p1_att_q;
  assign p2_evt = p2_attack & ~p2_att_q;

  // Victim's cooldown gates the hit; the attacker's own cooldown is irrelevant.
  assign land_on_p2 = p1_evt & collision & (p2_cd_q == '0);
  assign land_on_p1 = p2_evt & collision & (p1_cd_q == '0);

  always_comb begin
    state_d     = state_q;
    win_d       = win_q;
    p1_health_d = p1_health_q;
    p2_health_d = p2_health_q;
    p1_hit_d    = 1'b0;
    p2_hit_d    = 1'b0;
    p1_cd_d     = (tick && p1_cd_q != '0) ? p1_cd_q - CD_W'(1) : p1_cd_q;
    p2_cd_d     = (tick && p2_cd_q != '0) ? p2_cd_q - CD_W'(1) : p2_cd_q;

    if (round_start) begin
      state_d     = ST_FIGHT;
      win_d       = WIN_NONE;
      p1_health_d = H_MAX;
      p2_health_d = H_MAX;
      p1_cd_d     = '0;
      p2_cd_d     = '0;
    end else begin
      case (state_q)
        ST_FIGHT: begin
          if (land_on_p1) begin
            p1_health_d = apply_damage(p1_health_q, H_DMG);
            p1_hit_d    = 1'b1;
            p1_cd_d     = CD_LOAD;
          end
          if (land_on_p2) begin
            p2_health_d = apply_damage(p2_health_q, H_DMG);
            p2_hit_d    = 1'b1;
            p2_cd_d     = CD_LOAD;
          end
          if (p1_health_d == '0 || p2_health_d == '0) begin
            state_d = ST_KO;
            if (p1_health_d == '0 && p2_health_d == '0) win_d = WIN_DRAW;
            else if (p2_health_d == '0)                  win_d = WIN_P1;
            else                                         win_d = WIN_P2;
          end
        end
        ST_IDLE, ST_KO: ;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      win_q       <= WIN_NONE;
      p1_health_q <= '0;
      p2_health_q <= '0;
      p1_cd_q     <= '0;
      p2_cd_q     <= '0;
      p1_att_q    <= 1'b0;
      p2_att_q    <= 1'b0;
      p1_hit_q    <= 1'b0;
      p2_hit_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      win_q       <= win_d;
      p1_health_q <= p1_health_d;
      p2_health_q <= p2_health_d;
      p1_cd_q     <= p1_cd_d;
      p2_cd_q     <= p2_cd_d;
      p1_att_q    <= p1_attack;
      p2_att_q    <= p2_attack;
      p1_hit_q    <= p1_hit_d;
      p2_hit_q    <= p2_hit_d;
    end
  end

  assign p1_health = p1_health_q;
  assign p2_health = p2_health_q;
  assign p1_hit    = p1_hit_q;
  assign p2_hit    = p2_hit_q;
  assign ko        = (state_q == ST_KO);
  assign winner    = win_q;

endmodule

// File: tb/tb_hit_resolver.sv
// Directed bench for hit_resolver: a cycle-level game model checked every
// cycle plus literal checkpoints along a scripted round.
module tb_hit_resolver;

  localparam int TD  = 4;
  localparam int CDT = 2;
  localparam int MH  = 30;
  localparam int DMG = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0, collision = 1'b0, p1_attack = 1'b0, p2_attack = 1'b0, round_start = 1'b0;
  logic [6:0] p1_health, p2_health, q5_p1_health, q5_p2_health;
  logic       p1_hit, p2_hit, ko, q5_p1_hit, q5_p2_hit, q5_ko;
  logic [1:0] winner, q5_winner;

  always #5 clk = ~clk;

  hit_resolver #(
    .MAX_HEALTH     (MH),
    .DAMAGE         (DMG),
    .TICK_DIV       (TD),
    .COOLDOWN_TICKS (CDT)
  ) dut (
    .clk (clk), .rst_n (rst_n), .collision (collision),
    .p1_attack (p1_attack), .p2_attack (p2_attack), .round_start (round_start),
    .p1_health (p1_health), .p2_health (p2_health),
    .p1_hit (p1_hit), .p2_hit (p2_hit), .ko (ko), .winner (winner)
  );

  // Low starting health so a single hit exercises saturation at zero.
  hit_resolver #(
    .MAX_HEALTH     (5),
    .DAMAGE         (DMG),
    .TICK_DIV       (TD),
    .COOLDOWN_TICKS (CDT)
  ) dut5 (
    .clk (clk), .rst_n (rst_n), .collision (collision),
    .p1_attack (p1_attack), .p2_attack (p2_attack), .round_start (round_start),
    .p1_health (q5_p1_health), .p2_health (q5_p2_health),
    .p1_hit (q5_p1_hit), .p2_hit (q5_p2_hit), .ko (q5_ko), .winner (q5_winner)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Game model: phase 0 idle, 1 fight, 2 KO; winner 0 none, 1 P1, 2 P2, 3 draw.
  int m_h1, m_h2, m_cd1, m_cd2, m_tc, m_phase, m_win;
  bit m_prev1, m_prev2, m_hit1, m_hit2;

  function automatic int hurt(input int h);
    return (h <= DMG) ? 0 : h - DMG;
  endfunction

  always @(posedge clk) begin : model
    int h1, h2, cd1, cd2, ph, w;
    bit tk, e1, e2, hi1, hi2;
    if (!rst_n) begin
      m_h1 <= 0; m_h2 <= 0; m_cd1 <= 0; m_cd2 <= 0; m_tc <= 0;
      m_phase <= 0; m_win <= 0; m_prev1 <= 0; m_prev2 <= 0;
      m_hit1 <= 0; m_hit2 <= 0;
    end else begin
      tk = (m_tc == TD - 1);
      e1 = p1_attack && !m_prev1;
      e2 = p2_attack && !m_prev2;
      h1 = m_h1; h2 = m_h2; ph = m_phase; w = m_win;
      cd1 = (tk && m_cd1 > 0) ? m_cd1 - 1 : m_cd1;
      cd2 = (tk && m_cd2 > 0) ? m_cd2 - 1 : m_cd2;
      hi1 = 0; hi2 = 0;
      if (round_start) begin
        ph = 1; h1 = MH; h2 = MH; cd1 = 0; cd2 = 0; w = 0;
      end else if (ph == 1) begin
        if (e1 && collision && m_cd2 == 0) begin h2 = hurt(h2); hi2 = 1; cd2 = CDT; end
        if (e2 && collision && m_cd1 == 0) begin h1 = hurt(h1); hi1 = 1; cd1 = CDT; end
        if (h1 == 0 || h2 == 0) begin
          ph = 2;
          w  = (h1 == 0 && h2 == 0) ? 3 : (h2 == 0) ? 1 : 2;
        end
      end
      m_tc <= tk ? 0 : m_tc + 1;
      m_prev1 <= p1_attack; m_prev2 <= p2_attack;
      m_h1 <= h1; m_h2 <= h2; m_cd1 <= cd1; m_cd2 <= cd2;
      m_phase <= ph; m_win <= w; m_hit1 <= hi1; m_hit2 <= hi2;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model p1_health", p1_health, m_h1);
      chk("model p2_health", p2_health, m_h2);
      chk("model p1_hit", p1_hit, m_hit1);
      chk("model p2_hit", p2_hit, m_hit2);
      chk("model ko", ko, (m_phase == 2));
      chk("model winner", winner, m_win);
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("rst p1_health", p1_health, 0);
    chk("rst p2_health", p2_health, 0);
    chk("rst hits", {p1_hit, p2_hit}, 0);
    chk("rst ko", ko, 0);
    chk("rst winner", winner, 0);

    rst_n = 1'b1; round_start = 1'b1;
    @(negedge clk); round_start = 1'b0;
    chk("start p1_health", p1_health, 30);
    chk("start p2_health", p2_health, 30);
    chk("start winner", winner, 0);
    chk("start ko", ko, 0);
    chk("q5 start health", q5_p2_health, 5);

    collision = 1'b1; p1_attack = 1'b1;
    @(negedge clk);
    chk("hit1 p2_health", p2_health, 20);
    chk("hit1 p2_hit", p2_hit, 1);
    chk("hit1 p1_health", p1_health, 30);
    chk("q5 saturate p2_health", q5_p2_health, 0);
    chk("q5 ko", q5_ko, 1);
    chk("q5 winner", q5_winner, 1);
    @(negedge clk);
    chk("hit1 pulse drop", p2_hit, 0);

    @(negedge clk); p1_attack = 1'b0;
    @(negedge clk); p1_attack = 1'b1;
    @(negedge clk);
    chk("cooldown blocks p2_health", p2_health, 20);
    chk("cooldown blocks p2_hit", p2_hit, 0);
    repeat (20) @(negedge clk);
    chk("held attack p2_health", p2_health, 20);

    p1_attack = 1'b0;
    @(negedge clk); p1_attack = 1'b1;
    @(negedge clk);
    chk("after cooldown p2_health", p2_health, 10);
    chk("after cooldown p2_hit", p2_hit, 1);

    p1_attack = 1'b0; collision = 1'b0;
    repeat (10) @(negedge clk); p1_attack = 1'b1;
    @(negedge clk);
    chk("no collision p2_health", p2_health, 10);
    chk("no collision p2_hit", p2_hit, 0);

    collision = 1'b1; p1_attack = 1'b0; p2_attack = 1'b1;
    @(negedge clk);
    chk("p2 hits p1 health", p1_health, 20);
    chk("p2 hits p1 pulse", p1_hit, 1);
    p2_attack = 1'b0;
    repeat (9) @(negedge clk); p2_attack = 1'b1;
    @(negedge clk);
    chk("p2 hits p1 again", p1_health, 10);

    p2_attack = 1'b0;
    repeat (10) @(negedge clk);
    p1_attack = 1'b1; p2_attack = 1'b1;
    @(negedge clk);
    chk("draw p1_health", p1_health, 0);
    chk("draw p2_health", p2_health, 0);
    chk("draw ko", ko, 1);
    chk("draw winner", winner, 3);
    chk("draw hits", {p1_hit, p2_hit}, 3);

    p1_attack = 1'b0; p2_attack = 1'b0;
    @(negedge clk); p1_attack = 1'b1; p2_attack = 1'b1;
    @(negedge clk);
    chk("ko ignore hits", {p1_hit, p2_hit}, 0);
    chk("ko hold winner", winner, 3);
    chk("ko hold ko", ko, 1);

    p1_attack = 1'b0; p2_attack = 1'b0; round_start = 1'b1;
    @(negedge clk); round_start = 1'b0;
    chk("restart p1_health", p1_health, 30);
    chk("restart p2_health", p2_health, 30);
    chk("restart ko", ko, 0);
    chk("restart winner", winner, 0);

    p1_attack = 1'b1;
    @(negedge clk);
    chk("pre-reset p2_hit", p2_hit, 1);
    rst_n = 1'b0; p1_attack = 1'b0;
    @(negedge clk);
    chk("mid reset p2_hit", p2_hit, 0);
    chk("mid reset p2_health", p2_health, 0);
    chk("mid reset ko", ko, 0);
    chk("mid reset winner", winner, 0);
    rst_n = 1'b1; p1_attack = 1'b1;
    @(negedge clk);
    chk("idle ignores attack", p2_health, 0);
    chk("idle no pulse", p2_hit, 0);
    p1_attack = 1'b0; round_start = 1'b1;
    @(negedge clk); round_start = 1'b0;
    chk("post reset start", p1_health, 30);
    @(negedge clk);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
